regfile_acc_alu: RTL and testbench
==================================

Name: regfile_acc_alu

Overview:
- 8-bit datapath slice of the basic processor: an 8x8 register file, an accumulator and an add/subtract unit, driven by the 4-bit opcode.
- Implements ADD, SUB, ADI, SBI (result to accumulator) and INR, DCR (result written back to the source register).
- Provides an external load port for register initialisation and a debug read port for observation.

Parameters:
- DATA_W, 8, datapath and register width.
- ADDR_W, 3, register address width (2**ADDR_W registers).
- ACC_INIT, 8'd10, accumulator value after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  issue strobe; opcode/rs1/rs2/imm sampled when high.
- opcode  in  4  operation select (encodings below).
- rs1  in  ADDR_W  first operand register; destination for INR/DCR.
- rs2  in  ADDR_W  second operand register (ADD/SUB only).
- imm  in  DATA_W  immediate operand (ADI/SBI).
- load_en  in  1  external register write enable.
- load_addr  in  ADDR_W  external write address.
- load_data  in  DATA_W  external write data.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  combinational read of register[dbg_addr].
- acc  out  DATA_W  accumulator contents (registered).
- cout  out  1  carry/borrow flag of the last executed operation (registered).
- done  out  1  one-cycle pulse: the operation has committed.

Behaviour:
- Reset (rst high at an edge):
  - all registers go to 0; acc goes to ACC_INIT; cout and done go to 0.
  - Any start or load sampled in the same cycle is discarded.
- Register file:
  - 2 asynchronous read ports (rs1, rs2) plus the debug port.
  - 1 synchronous write port.
  - Reads return pre-edge contents (read-before-write).
- Opcodes (valid only when start=1):
  - 0010 ADD: acc <= R[rs1] + R[rs2].
  - 0011 SUB: acc <= R[rs1] - R[rs2].
  - 0111 ADI: acc <= R[rs1] + imm.
  - 1001 SBI: acc <= R[rs1] - imm.
  - 0101 INR: R[rs1] <= R[rs1] + 1; acc unchanged.
  - 0110 DCR: R[rs1] <= R[rs1] - 1; acc unchanged.
- Arithmetic:
  - Modulo 2**DATA_W; results wrap.
  - Add: cout = carry out of bit DATA_W-1.
  - Subtract: cout = 1 iff borrow, i.e. unsigned minuend < subtrahend.
  - INR of 0xFF gives 0x00 with cout=1; DCR of 0x00 gives 0xFF with cout=1.
- Timing:
  - Operands are read combinationally in the cycle start is high.
  - The result, cout and the destination update commit at that same rising edge.
  - done is high for exactly the following cycle.
  - No busy state: start may be asserted every cycle (back-to-back ops). Each op sees the results of all earlier ops because they committed at prior edges.
- Invalid opcodes with start=1 (all other encodings): no state change; done stays 0; cout holds its value.
- start=0: done=0; acc, cout and registers hold, except for load-port writes.
- Load port:
  - load_en=1 writes load_data to R[load_addr] at the edge.
  - If INR/DCR is accepted in the same cycle, the ALU writeback wins and the load is dropped, regardless of address.
  - A load concurrent with ADD/SUB/ADI/SBI is performed; those ops read pre-load values.
- rs1==rs2 is legal (e.g. SUB gives 0, cout=0).
- Reset mid-operation: rst takes priority over any commit; done=0 in the next cycle.

Test Plan:
- Reset: assert rst 1 cycle -> acc=10, cout=0, done=0, dbg_data=0 for all 8 addresses.
- Load R1=0x05, R2=0x03; ADD rs1=1 rs2=2 -> acc=0x08, cout=0, done pulses 1 cycle. SUB -> acc=0x02, cout=0. SUB rs1=2 rs2=1 -> acc=0xFE, cout=1.
- Load R3=0xF0; ADI rs1=3 imm=0x20 -> acc=0x10, cout=1. SBI rs1=3 imm=0xF0 -> acc=0x00, cout=0.
- Load R4=0xFF; INR rs1=4 -> R4=0x00, cout=1, acc unchanged. DCR rs1=4 -> R4=0xFF, cout=1. Back-to-back INR,INR on R5=0 -> R5=2, two done pulses.
- Same cycle: INR rs1=6 (R6=7) with load_en to R6=0x55 -> R6=0x08. Opcode 1111 with start -> no done, acc and cout unchanged.
- Assert rst in the same cycle as ADD start -> acc=10, done stays 0, registers cleared.

Source files
------------

// File: rtl/regfile_acc_alu.sv
// 8-bit datapath slice: register file, accumulator and add/subtract unit.
// Ops commit on the edge where start is sampled; done pulses the following cycle.
module regfile_acc_alu #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter logic [DATA_W-1:0] ACC_INIT = DATA_W'(10)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [DATA_W-1:0] imm,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] acc,
    output logic              cout,
    output logic              done
);

    localparam int NREGS = 1 << ADDR_W;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_INR = 4'b0101;
    localparam logic [3:0] OP_DCR = 4'b0110;
    localparam logic [3:0] OP_ADI = 4'b0111;
    localparam logic [3:0] OP_SBI = 4'b1001;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              cout_q, cout_d;
    logic              done_q, done_d;

    logic              regWe;
    logic [ADDR_W-1:0] regWAddr;
    logic [DATA_W-1:0] regWData;

    logic [DATA_W-1:0] opA, opB;
    logic              isSub, opValid, writesAcc, writesReg, opFires;
    logic [DATA_W:0]   aluRes;

    // Subtraction in DATA_W+1 bits leaves the borrow in the top bit, mirroring the add carry.
    always_comb begin
        opA       = regs_q[rs1];
        opB       = regs_q[rs2];
        isSub     = 1'b0;
        opValid   = 1'b1;
        writesAcc = 1'b0;
        writesReg = 1'b0;
        case (opcode)
            OP_ADD: writesAcc = 1'b1;
            OP_SUB: begin
                writesAcc = 1'b1;
                isSub     = 1'b1;
            end
            OP_ADI: begin
                opB       = imm;
                writesAcc = 1'b1;
            end
            OP_SBI: begin
                opB       = imm;
                isSub     = 1'b1;
                writesAcc = 1'b1;
            end
            OP_INR: begin
                opB       = DATA_W'(1);
                writesReg = 1'b1;
            end
            OP_DCR: begin
                opB       = DATA_W'(1);
                isSub     = 1'b1;
                writesReg = 1'b1;
            end
            default: opValid = 1'b0;
        endcase
        aluRes  = isSub ? ({1'b0, opA} - {1'b0, opB}) : ({1'b0, opA} + {1'b0, opB});
        opFires = start && opValid;
    end

    // INR/DCR writeback owns the single write port; a concurrent load is dropped.
    always_comb begin
        acc_d    = acc_q;
        cout_d   = cout_q;
        done_d   = 1'b0;
        regWe    = 1'b0;
        regWAddr = load_addr;
        regWData = load_data;
        if (opFires) begin
            done_d = 1'b1;
            cout_d = aluRes[DATA_W];
            if (writesAcc) begin
                acc_d = aluRes[DATA_W-1:0];
            end
        end
        if (opFires && writesReg) begin
            regWe    = 1'b1;
            regWAddr = rs1;
            regWData = aluRes[DATA_W-1:0];
        end else if (load_en) begin
            regWe = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            acc_q  <= ACC_INIT;
            cout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (regWe) begin
                regs_q[regWAddr] <= regWData;
            end
            acc_q  <= acc_d;
            cout_q <= cout_d;
            done_q <= done_d;
        end
    end

    assign dbg_data = regs_q[dbg_addr];
    assign acc      = acc_q;
    assign cout     = cout_q;
    assign done     = done_q;

endmodule

// File: tb/tb_regfile_acc_alu.sv
// Self-checking bench for regfile_acc_alu: directed plan plus random traffic,
// compared every cycle against an integer-arithmetic model of the register file and accumulator.
module tb_regfile_acc_alu;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0011;
    localparam logic [3:0] INR = 4'b0101;
    localparam logic [3:0] DCR = 4'b0110;
    localparam logic [3:0] ADI = 4'b0111;
    localparam logic [3:0] SBI = 4'b1001;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] opcode;
    logic [2:0] rs1, rs2;
    logic [7:0] imm;
    logic       loadEn;
    logic [2:0] loadAddr;
    logic [7:0] loadData;
    logic [2:0] dbgAddr;
    logic [7:0] dbgData;
    logic [7:0] acc;
    logic       cout;
    logic       done;

    int checks   = 0;
    int failures = 0;

    int mRegs [8];
    int mAcc;
    int mCout;
    int mDone;
    bit modelValid = 1'b0;

    regfile_acc_alu dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .load_en  (loadEn),
        .load_addr(loadAddr),
        .load_data(loadData),
        .dbg_addr (dbgAddr),
        .dbg_data (dbgData),
        .acc      (acc),
        .cout     (cout),
        .done     (done)
    );

    always #10 clk = ~clk;

    // Reference model: plain unsigned integer arithmetic, wrap by modulo 256.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mRegs[i] = 0;
            mAcc  = 10;
            mCout = 0;
            mDone = 0;
            modelValid = 1'b1;
        end else begin
            int a, b, r;
            bit regWrite;
            regWrite = 1'b0;
            r = 0;
            mDone = 0;
            a = mRegs[rs1];
            b = mRegs[rs2];
            if (start) begin
                case (opcode)
                    ADD: begin r = a + b;   mAcc = r % 256; mCout = (r > 255) ? 1 : 0; mDone = 1; end
                    SUB: begin mAcc = (a - b + 256) % 256;   mCout = (a < b) ? 1 : 0;   mDone = 1; end
                    ADI: begin r = a + int'(imm); mAcc = r % 256; mCout = (r > 255) ? 1 : 0; mDone = 1; end
                    SBI: begin mAcc = (a - int'(imm) + 256) % 256; mCout = (a < int'(imm)) ? 1 : 0; mDone = 1; end
                    INR: begin r = (a + 1) % 256;   mCout = (a == 255) ? 1 : 0; regWrite = 1'b1; mDone = 1; end
                    DCR: begin r = (a + 255) % 256; mCout = (a == 0) ? 1 : 0;   regWrite = 1'b1; mDone = 1; end
                    default: ;
                endcase
            end
            if (regWrite) mRegs[rs1] = r;
            else if (loadEn) mRegs[loadAddr] = int'(loadData);
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: DUT outputs are stable mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("acc", acc, 8'(mAcc));
            checkOutput("cout", {7'd0, cout}, 8'(mCout));
            checkOutput("done", {7'd0, done}, 8'(mDone));
            checkOutput("dbg_data", dbgData, 8'(mRegs[dbgAddr]));
        end
    end

    // Drive one cycle of inputs, then return just after the edge that samples them.
    task automatic applyStimulus(input logic s, input logic [3:0] op, input logic [2:0] a,
                                 input logic [2:0] b, input logic [7:0] im, input logic le,
                                 input logic [2:0] la, input logic [7:0] ld);
        start    = s;
        opcode   = op;
        rs1      = a;
        rs2      = b;
        imm      = im;
        loadEn   = le;
        loadAddr = la;
        loadData = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, 3'd0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0);
    endtask

    task automatic loadReg(input logic [2:0] la, input logic [7:0] ld);
        applyStimulus(1'b0, 4'd0, 3'd0, 3'd0, 8'd0, 1'b1, la, ld);
    endtask

    task automatic doOp(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b, input logic [7:0] im);
        applyStimulus(1'b1, op, a, b, im, 1'b0, 3'd0, 8'd0);
    endtask

    task automatic checkReg(input string name, input logic [2:0] addr, input logic [7:0] expected);
        dbgAddr = addr;
        #1;
        checkOutput(name, dbgData, expected);
    endtask

    task automatic checkAllZero(input string name);
        for (int i = 0; i < 8; i++) begin
            dbgAddr = 3'(i);
            #1;
            checkOutput(name, dbgData, 8'h00);
        end
    endtask

    initial begin
        rst = 1'b1;
        dbgAddr = 3'd0;
        idleCycle();
        rst = 1'b0;
        checkOutput("reset acc", acc, 8'd10);
        checkOutput("reset cout", {7'd0, cout}, 8'd0);
        checkOutput("reset done", {7'd0, done}, 8'd0);
        checkAllZero("reset regs");

        loadReg(3'd1, 8'h05);
        loadReg(3'd2, 8'h03);
        doOp(ADD, 3'd1, 3'd2, 8'h00);
        checkOutput("ADD acc", acc, 8'h08);
        checkOutput("ADD cout", {7'd0, cout}, 8'd0);
        checkOutput("ADD done", {7'd0, done}, 8'd1);
        idleCycle();
        checkOutput("done one cycle", {7'd0, done}, 8'd0);
        doOp(SUB, 3'd1, 3'd2, 8'h00);
        checkOutput("SUB acc", acc, 8'h02);
        checkOutput("SUB cout", {7'd0, cout}, 8'd0);
        doOp(SUB, 3'd2, 3'd1, 8'h00);
        checkOutput("SUB borrow acc", acc, 8'hFE);
        checkOutput("SUB borrow cout", {7'd0, cout}, 8'd1);

        loadReg(3'd3, 8'hF0);
        doOp(ADI, 3'd3, 3'd0, 8'h20);
        checkOutput("ADI acc", acc, 8'h10);
        checkOutput("ADI cout", {7'd0, cout}, 8'd1);
        doOp(SBI, 3'd3, 3'd0, 8'hF0);
        checkOutput("SBI acc", acc, 8'h00);
        checkOutput("SBI cout", {7'd0, cout}, 8'd0);

        loadReg(3'd4, 8'hFF);
        doOp(INR, 3'd4, 3'd0, 8'h00);
        checkReg("INR wrap R4", 3'd4, 8'h00);
        checkOutput("INR cout", {7'd0, cout}, 8'd1);
        checkOutput("INR acc held", acc, 8'h00);
        doOp(DCR, 3'd4, 3'd0, 8'h00);
        checkReg("DCR wrap R4", 3'd4, 8'hFF);
        checkOutput("DCR cout", {7'd0, cout}, 8'd1);

        doOp(INR, 3'd5, 3'd0, 8'h00);
        checkOutput("INR b2b done1", {7'd0, done}, 8'd1);
        doOp(INR, 3'd5, 3'd0, 8'h00);
        checkOutput("INR b2b done2", {7'd0, done}, 8'd1);
        idleCycle();
        checkReg("INR b2b R5", 3'd5, 8'h02);

        loadReg(3'd6, 8'h07);
        applyStimulus(1'b1, INR, 3'd6, 3'd0, 8'h00, 1'b1, 3'd6, 8'h55);
        checkReg("INR beats load R6", 3'd6, 8'h08);

        doOp(SUB, 3'd2, 3'd1, 8'h00);
        doOp(4'b1111, 3'd1, 3'd2, 8'h00);
        checkOutput("invalid done", {7'd0, done}, 8'd0);
        checkOutput("invalid acc held", acc, 8'hFE);
        checkOutput("invalid cout held", {7'd0, cout}, 8'd1);

        rst = 1'b1;
        doOp(ADD, 3'd1, 3'd2, 8'h00);
        rst = 1'b0;
        idleCycle();
        checkOutput("rst vs ADD acc", acc, 8'd10);
        checkOutput("rst vs ADD done", {7'd0, done}, 8'd0);
        checkAllZero("rst vs ADD regs");

        for (int n = 0; n < 2000; n++) begin
            rst     = ($urandom_range(0, 63) == 0);
            dbgAddr = 3'($urandom_range(0, 7));
            applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
        end
        rst = 1'b0;
        idleCycle();
        idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
